// File: rtl/uart_pkg.sv
// Shared UART definitions: default timing, bit-period helpers and the TX FSM state type.
// The receiver reuses the same helpers so both ends agree on bit timing.
package uart_pkg;

    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int BPS_DEF      = 9600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Clocks per bit; the caller keeps the result within 2..65535.
    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    // Clocks from the first start-bit cycle until the transmitter is idle again.
    function automatic int frame_clks(input int cnt, input int parity_en, input int stop_bits);
        return (10 + parity_en + stop_bits - 1) * cnt;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs while enabled, pulses bit_end_o on the last clock of
// each bit and restarts from zero whenever it is disabled.
import uart_pkg::*;

module uart_baud_gen #(
    parameter int CNT_MAX = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic bit_end_o
);

    localparam logic [15:0] LAST = 16'(CNT_MAX - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign bit_end_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!en_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted request, framed as start, D0..D7,
// optional parity and 1 or 2 stop bits; uart_txd comes straight from a flop.
import uart_pkg::*;

module uart_tx #(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BPS        = BPS_DEF,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       uart_txd
);

    // Handshake: a byte is taken on any rising edge where tx_start and tx_ready
    // are both high; tx_ready stays low until the last stop bit has finished.
    localparam int   BPS_CNT   = bps_cnt(CLK_FREQ, BPS);
    localparam logic ODD_BIT   = (PARITY_ODD != 0);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    tx_state_e   state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        done_q, done_d;
    logic        bit_end;

    uart_baud_gen #(
        .CNT_MAX (BPS_CNT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q != IDLE),
        .bit_end_o (bit_end)
    );

    assign tx_ready = (state_q == IDLE);
    assign tx_done  = done_q;
    assign uart_txd = txd_q;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d    = START;
                    txd_d      = 1'b0;
                    shift_d    = tx_data;
                    par_d      = (^tx_data) ^ ODD_BIT;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1 at two clocks per bit)
// checked clock by clock against a frame model and a mid-bit receiver.
module tb_uart_tx;

    localparam int BC [3] = '{10, 7, 2};
    localparam int PE [3] = '{0, 1, 1};
    localparam int PO [3] = '{0, 0, 1};
    localparam int SB [3] = '{1, 2, 1};

    logic       clk;
    logic       rst_n;
    logic [2:0] st;
    logic [2:0] rdy;
    logic [2:0] done;
    logic [2:0] txd;
    logic [7:0] dat [3];

    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_err    = 0;

    uart_tx #(.CLK_FREQ(1000), .BPS(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_start(st[0]), .tx_data(dat[0]),
        .tx_ready(rdy[0]), .tx_done(done[0]), .uart_txd(txd[0]));
    uart_tx #(.CLK_FREQ(700), .BPS(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_start(st[1]), .tx_data(dat[1]),
        .tx_ready(rdy[1]), .tx_done(done[1]), .uart_txd(txd[1]));
    uart_tx #(.CLK_FREQ(200), .BPS(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_start(st[2]), .tx_data(dat[2]),
        .tx_ready(rdy[2]), .tx_done(done[2]), .uart_txd(txd[2]));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: line level of bit k in a frame carrying d
    function automatic logic model_bit(input int idx, input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PE[idx] != 0 && k == 9) return (PO[idx] != 0) ? ~^d : ^d;
        return 1'b1;
    endfunction

    function automatic int frame_bits(input int idx);
        return 10 + PE[idx] + SB[idx] - 1;
    endfunction

    // driver + frame checker: request d, then check every clock of the frame
    task automatic xmit(input int idx, input logic [7:0] d, input bit keep,
                        input logic [7:0] next_d, input bit glitch, input bit expect_now);
        int waited;
        logic [7:0] exp_b;
        logic [7:0] rx;
        logic obs;
        logic e;
        bit rbad;
        @(negedge clk);
        st[idx]  = 1'b1;
        dat[idx] = d;
        exp_q.push_back(d);
        waited = 0;
        while (!rdy[idx] && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[idx]) begin
            check("accept_timeout", 32'd0, 32'd1);
            st[idx] = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        if (expect_now) check("b2b_gap", waited, 32'd0);
        @(posedge clk);
        #1;
        if (keep) begin
            dat[idx] = next_d;
        end else begin
            st[idx]  = 1'b0;
            dat[idx] = 8'($urandom);
        end
        exp_b = exp_q.pop_front();
        rx    = '0;
        rbad  = 1'b0;
        for (int k = 0; k < frame_bits(idx); k++) begin
            e   = model_bit(idx, exp_b, k);
            obs = e;
            for (int c = 0; c < BC[idx]; c++) begin
                if (txd[idx] !== e) obs = txd[idx];
                if (rdy[idx] !== 1'b0 || done[idx] !== 1'b0) rbad = 1'b1;
                if (c == BC[idx] / 2 && k >= 1 && k <= 8) rx[k-1] = txd[idx];
                if (glitch && k == 5 && c == 0) begin
                    st[idx]  = 1'b1;
                    dat[idx] = 8'hFF;
                end
                if (glitch && k == 5 && c == 1) begin
                    st[idx]  = 1'b0;
                    dat[idx] = 8'($urandom);
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("dut%0d_bit%0d", idx, k), obs, e);
        end
        check("busy_flags", rbad, 1'b0);
        check("rx_byte", rx, exp_b);
        check("done_pulse", done[idx], 1'b1);
        check("ready_end", rdy[idx], 1'b1);
        check("txd_end", txd[idx], 1'b1);
        if (!keep) begin
            @(posedge clk);
            #1;
            check("done_low", done[idx], 1'b0);
        end
    endtask

    // assert reset off-edge while dut0 is in D4 and expect immediate idle outputs
    task automatic reset_mid_frame();
        @(negedge clk);
        st[0]  = 1'b1;
        dat[0] = 8'hE5;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (5 * BC[0] + 3) @(posedge clk);
        #1;
        check("pre_reset_d4", txd[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_txd", txd[0], 1'b1);
        check("async_rst_ready", rdy[0], 1'b1);
        check("async_rst_done", done[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit bad;
        logic [7:0] d1;
        logic [7:0] d2;
        int idx;
        rst_n = 1'b0;
        st    = '0;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        #23;
        check("rst_txd", txd, 3'b111);
        check("rst_ready", rdy, 3'b111);
        check("rst_done", done, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 3'b111 || rdy !== 3'b111 || done !== 3'b000) bad = 1'b1;
        end
        check("idle_stable", bad, 1'b0);

        xmit(0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
        xmit(0, 8'hA3, 1'b1, 8'h0F, 1'b0, 1'b0);
        xmit(0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b1);
        xmit(1, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0);
        xmit(2, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0);
        xmit(2, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        xmit(2, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
        xmit(0, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0);
        xmit(1, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0);

        reset_mid_frame();
        xmit(0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);

        repeat (24) begin
            idx = $urandom_range(0, 2);
            d1  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                d2 = 8'($urandom);
                xmit(idx, d1, 1'b1, d2, 1'b0, 1'b0);
                xmit(idx, d2, 1'b0, 8'h00, 1'b0, 1'b1);
            end else begin
                xmit(idx, d1, 1'b0, 8'h00, 1'b0, 1'b0);
            end
        end

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
